muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_unit.sv | 123 ++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and operand-signedness helpers
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add multiply or restoring divide iteration
module muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic            div,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  // Multiply: hi is the running partial product, lo the multiplier shifting out.
  // Divide: hi is the partial remainder, lo the dividend shifting into the quotient.
  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand_b} : '0);
    shifted = {hi_in, lo_in[XLEN-1]};
    diff    = shifted - {1'b0, operand_b};
    fits    = ~diff[XLEN];
    if (div) begin
      hi_out = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      lo_out = {lo_in[XLEN-2:0], fits};
    end else begin
      hi_out = sum[XLEN:1];
      lo_out = {sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64M multiply/divide unit, one bit per cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [4:0]        rd_q;
  logic              neg_q, rem_neg, div0, ovf;
  logic [XLEN-1:0]   hi, lo, b_mag;
  logic [XLEN-1:0]   step_hi, step_lo;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_value;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div       (is_div(op)),
    .hi_in     (hi),
    .lo_in     (lo),
    .operand_b (b_mag),
    .hi_out    (step_hi),
    .lo_out    (step_lo)
  );

  always_comb begin
    a_neg = rs1_signed(funct3) & rs1_data[XLEN-1];
    b_neg = rs2_signed(funct3) & rs2_data[XLEN-1];
    a_abs = a_neg ? -rs1_data : rs1_data;
    b_abs = b_neg ? -rs2_data : rs2_data;
  end

  // A zero divisor leaves the dividend magnitude in hi, so REM by zero needs no override.
  always_comb begin
    prod_fix = neg_q ? -{hi, lo} : {hi, lo};
    quo_fix  = div0 ? '1 : ovf ? {1'b1, {(XLEN-1){1'b0}}} : (neg_q ? -lo : lo);
    rem_fix  = ovf ? '0 : (rem_neg ? -hi : hi);
    case (op)
      OP_MUL:           fix_value = prod_fix[XLEN-1:0];
      OP_DIV, OP_DIVU:  fix_value = quo_fix;
      OP_REM, OP_REMU:  fix_value = rem_fix;
      default:          fix_value = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= OP_MUL;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      rem_neg <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      b_mag   <= '0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op      <= funct3;
          rd_q    <= rd_in;
          neg_q   <= a_neg ^ b_neg;
          rem_neg <= a_neg;
          div0    <= is_div(funct3) && (rs2_data == '0);
          ovf     <= is_div(funct3) && rs1_signed(funct3) &&
                     (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
          hi      <= '0;
          lo      <= a_abs;
          b_mag   <= b_abs;
          cnt     <= CNT_W'(XLEN - 1);
        end
        CALC: begin
          hi <= step_hi;
          lo <= step_lo;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          result <= fix_value;
          rd_out <= rd_q;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed and randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [63:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int fails = 0;

  muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ext(input logic [63:0] v, input logic sgn);
    return sgn ? {{64{v[63]}}, v} : {64'b0, v};
  endfunction

  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic         ovf;
    ovf = (a == MINV) && (b == ONES);
    case (op)
      3'd0: begin p = ext(a, 1'b1) * ext(b, 1'b1); return p[63:0];   end
      3'd1: begin p = ext(a, 1'b1) * ext(b, 1'b1); return p[127:64]; end
      3'd2: begin p = ext(a, 1'b1) * ext(b, 1'b0); return p[127:64]; end
      3'd3: begin p = ext(a, 1'b0) * ext(b, 1'b0); return p[127:64]; end
      3'd4: return (b == 0) ? ONES : ovf ? a : 64'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: return (b == 0) ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    funct3 = op; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rs1_data = {$urandom, $urandom};
    rs2_data = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
    end
    if (!done) n = 999;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    int n;
    launch(op, a, b, rd);
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'd65);
    check({tag, "_result"}, result, ref_model(op, a, b));
    check({tag, "_rd"}, 64'(rd_out), 64'(rd));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return ONES;
      2: return MINV;
      3: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int n;
    int pulses;
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_rd", 64'(rd_out), 64'd0);
    reset = 1'b0;

    launch(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
    check("mul_busy_after_accept", 64'(busy), 64'd1);
    wait_done(n);
    check("mul_latency", 64'(n), 64'd65);
    check("mul_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul_rd", 64'(rd_out), 64'd5);
    check("mul_busy_at_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("mul_done_one_cycle", 64'(done), 64'd0);
    check("mul_result_held", result, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op("mulhu_ones", 3'd3, ONES, ONES, 5'd1);
    check("mulhu_const", result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulh_ones", 3'd1, ONES, ONES, 5'd2);
    check("mulh_const", result, 64'd0);
    run_op("div_m7_2", 3'd4, -64'd7, 64'd2, 5'd3);
    check("div_const", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem_m7_2", 3'd6, -64'd7, 64'd2, 5'd4);
    check("rem_const", result, ONES);
    run_op("remu_100_7", 3'd7, 64'd100, 64'd7, 5'd6);
    check("remu_const", result, 64'd2);
    run_op("divu_by0", 3'd5, 64'h1234, 64'd0, 5'd7);
    check("divu_by0_const", result, ONES);
    run_op("rem_by0", 3'd6, 64'h1234, 64'd0, 5'd8);
    check("rem_by0_const", result, 64'h1234);
    run_op("div_ovf", 3'd4, MINV, ONES, 5'd9);
    check("div_ovf_const", result, MINV);
    run_op("rem_ovf", 3'd6, MINV, ONES, 5'd10);
    check("rem_ovf_const", result, 64'd0);
    run_op("rd_zero", 3'd0, 64'd3, 64'd4, 5'd0);

    // Re-pulsed start mid-operation must not disturb the op in flight.
    launch(3'd5, 64'd1000, 64'd9, 5'd11);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      if (n == 10) begin
        start = 1'b1; funct3 = 3'd0; rs1_data = 64'd5; rs2_data = 64'd6; rd_in = 5'd12;
      end else begin
        start = 1'b0;
      end
    end
    if (!done) n = 999;
    check("ignored_start_latency", 64'(n), 64'd65);
    check("ignored_start_result", result, 64'd111);
    check("ignored_start_rd", 64'(rd_out), 64'd11);

    // Back-to-back: launch from inside the done cycle.
    run_op("back_to_back", 3'd2, ONES, 64'd3, 5'd13);

    launch(3'd4, 64'd12345, 64'd17, 5'd14);
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_rd", 64'(rd_out), 64'd0);
    pulses = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    run_op("after_abort_mul", 3'd0, 64'd123456789, 64'd987654321, 5'd15);

    for (int i = 0; i < 40; i++) begin
      run_op("random", 3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
